pheromone_writer: RTL
=====================

Name: pheromone_writer

Overview:
- Downstream of the ant array in each game turn.
- After every ant has moved, it scans the ants in index order. Each ant carrying food gets a saturating pheromone deposit at its (X,Y) cell, done as a read-modify-write on the signal-grid memory port.
- When the scan completes, it pulses global_writing_flag. That pulse re-arms every ant's move FSM for the next turn.

Parameters:
- NUM_ANTS, 8, number of ants scanned; index width is $clog2(NUM_ANTS).
- DEPOSIT, 4, amount added to a cell per carrying ant; width SIGNAL_bits.
- X_bits, Y_bits and SIGNAL_bits come from the shared params package. They are not module parameters.

Ports:
- game_clk  in  1  game clock; all state on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse from turn control once all ants have moved.
- ant_X  in  [NUM_ANTS][X_bits]  per-ant X.
- ant_Y  in  [NUM_ANTS][Y_bits]  per-ant Y.
- ant_mouthFull  in  [NUM_ANTS]  per-ant carrying flag.
- ant_dropping  in  [NUM_ANTS]  per-ant dropping_sugar.
- mem_addr  out  X_bits+Y_bits  grid address, {Y,X}.
- mem_rd_en  out  1  read strobe; data is valid on mem_rd_data one cycle later.
- mem_rd_data  in  SIGNAL_bits  grid read data.
- mem_wr_en  out  1  write strobe.
- mem_wr_data  out  SIGNAL_bits  grid write data.
- busy  out  1  high in every state except IDLE.
- global_writing_flag  out  1  one-cycle pulse when the turn's writes are complete.
- sugar_delivered  out  16  delivered-sugar count (optional feature).

Behaviour:
- Reset values: all outputs 0, state IDLE, index 0, sugar_delivered 0. Reset is asynchronous and can interrupt any state.
- FSM states: IDLE, SCAN, READ, MODIFY, WRITE, FLAG.
- IDLE: waits for start. On start: index <= 0, go to SCAN.
- SCAN:
  - ant_mouthFull[index]=1: go to READ.
  - Otherwise, if index = NUM_ANTS-1: go to FLAG.
  - Otherwise: index++, stay in SCAN.
- READ: mem_addr = {ant_Y[index],ant_X[index]}, mem_rd_en=1. Go to MODIFY.
- MODIFY: register new = min(mem_rd_data + DEPOSIT, 2^SIGNAL_bits-1), computed at SIGNAL_bits+1 width. Go to WRITE.
- WRITE: mem_addr unchanged, mem_wr_en=1, mem_wr_data = registered value.
  - If index = NUM_ANTS-1: go to FLAG.
  - Otherwise: index++, go to SCAN.
- FLAG: global_writing_flag=1 for exactly one cycle, index <= 0, go to IDLE.
- Strobe decoding: mem_rd_en, mem_wr_en and global_writing_flag decode from state only. Reset in READ, MODIFY or WRITE therefore never issues a partial or late write.
- Latency: with D carrying ants, FLAG is the (NUM_ANTS + 3*D + 1)th cycle after the edge that samples start.
- start while busy: ignored; no restart and no queueing.
- Input stability: ant_* must be stable while busy. Turn control guarantees this, since ants move only between global_writing_flag and the next start. The block does not latch a snapshot.
- Shared cells: two ants on the same cell get two sequential RMWs. The second read returns the first write, so the cell accumulates 2*DEPOSIT, saturating.
- Saturation: a cell at max stays at max; no wrap-around.
- mem_addr is 0 outside READ and WRITE.

Optional Feature:
- Macro: PHER_STATS_EN.
- Defined: sugar_delivered is incremented by 1 in SCAN for each index with ant_dropping=1, saturating at 16'hFFFF. It is cleared only by RESET.
- Undefined: counter logic is absent and sugar_delivered is tied to 0.
- FSM timing is identical with or without the macro.

Decomposition:
- Shared params package: X_bits, Y_bits, SIGNAL_bits, and the grid address width constant (X_bits+Y_bits).
- Package typedef: pw_state_t enum for the FSM, exported for bench visibility.
- One sub-module is natural: sat_add, a parameterised saturating adder (WIDTH), used for the deposit. The stats counter reuses it with an increment of 1.

Test Plan:
- NUM_ANTS=4, no ant carrying; start pulse → no mem strobes; global_writing_flag high exactly on cycle 5 after start; busy high cycles 1-5.
- Ant 2 carrying at (X=3,Y=5), cell holds 10, DEPOSIT=4 → one read then one write at addr {5,3} with data 14; flag on cycle 8.
- Cell holds 2^SIGNAL_bits-2, DEPOSIT=4 → written value is 2^SIGNAL_bits-1; repeat turn → stays at max.
- Ants 0 and 1 both carrying at the same cell holding 0 → writes of 4, then 8, at the same address; flag on cycle 11.
- Assert RESET during WRITE of ant 1 → mem_wr_en drops immediately; no flag; FSM in IDLE; a following start runs a full, clean scan.
- With PHER_STATS_EN, ants 1 and 3 dropping → sugar_delivered = 2 after the turn, 4 after a repeat; start during busy → ignored, single flag.

Source files
------------

// File: rtl/pheromone_writer_pkg.sv
// Shared grid parameters and FSM state type for the pheromone writer.
// Grid cells are addressed as {Y,X}.
package pheromone_writer_pkg;

    localparam int X_bits      = 4;
    localparam int Y_bits      = 4;
    localparam int SIGNAL_bits = 8;
    localparam int ADDR_bits   = X_bits + Y_bits;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SCAN   = 3'd1,
        READ   = 3'd2,
        MODIFY = 3'd3,
        WRITE  = 3'd4,
        FLAG   = 3'd5
    } pw_state_t;

endpackage

// File: rtl/pheromone_writer_sat_add.sv
// Unsigned adder that clamps to all-ones instead of wrapping.
// The carry out of a WIDTH+1 bit sum selects the clamp.
module sat_add #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum
);

    logic [WIDTH:0] full;

    assign full = {1'b0, a} + {1'b0, b};
    assign sum  = full[WIDTH] ? {WIDTH{1'b1}} : full[WIDTH-1:0];

endmodule

// File: rtl/pheromone_writer.sv
// Per-turn pheromone deposit: scans ants and does a saturating RMW per carrier.
// Define PHER_STATS_EN to enable the sugar_delivered counter.
module pheromone_writer
    import pheromone_writer_pkg::*;
#(
    parameter int                     NUM_ANTS = 8,
    parameter logic [SIGNAL_bits-1:0] DEPOSIT  = 4
) (
    input  logic                                game_clk,
    input  logic                                RESET,
    input  logic                                start,
    input  logic [NUM_ANTS-1:0][X_bits-1:0]     ant_X,
    input  logic [NUM_ANTS-1:0][Y_bits-1:0]     ant_Y,
    input  logic [NUM_ANTS-1:0]                 ant_mouthFull,
    input  logic [NUM_ANTS-1:0]                 ant_dropping,
    output logic [ADDR_bits-1:0]                mem_addr,
    output logic                                mem_rd_en,
    input  logic [SIGNAL_bits-1:0]              mem_rd_data,
    output logic                                mem_wr_en,
    output logic [SIGNAL_bits-1:0]              mem_wr_data,
    output logic                                busy,
    output logic                                global_writing_flag,
    output logic [15:0]                         sugar_delivered
);

    localparam int IDX_W = (NUM_ANTS > 1) ? $clog2(NUM_ANTS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ANTS - 1);

    pw_state_t              state;
    pw_state_t              state_next;
    logic [IDX_W-1:0]       idx;
    logic [IDX_W-1:0]       idx_next;
    logic [SIGNAL_bits-1:0] new_val;
    logic [SIGNAL_bits-1:0] dep_sum;
    logic [ADDR_bits-1:0]   cur_addr;
    logic                   last;

    assign cur_addr = {ant_Y[idx], ant_X[idx]};
    assign last     = (idx == LAST_IDX);

    sat_add #(
        .WIDTH (SIGNAL_bits)
    ) u_dep (
        .a   (mem_rd_data),
        .b   (DEPOSIT),
        .sum (dep_sum)
    );

    always_ff @(posedge game_clk or posedge RESET) begin
        if (RESET) begin
            state   <= IDLE;
            idx     <= '0;
            new_val <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
            if (state == MODIFY) begin
                new_val <= dep_sum;
            end
        end
    end

    // Strobes decode from state alone so reset can never leave a late write.
    always_comb begin
        state_next          = state;
        idx_next            = idx;
        mem_addr            = '0;
        mem_rd_en           = 1'b0;
        mem_wr_en           = 1'b0;
        mem_wr_data         = '0;
        global_writing_flag = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    idx_next   = '0;
                    state_next = SCAN;
                end
            end
            SCAN: begin
                if (ant_mouthFull[idx]) begin
                    state_next = READ;
                end else if (last) begin
                    state_next = FLAG;
                end else begin
                    idx_next = idx + 1'b1;
                end
            end
            READ: begin
                mem_addr   = cur_addr;
                mem_rd_en  = 1'b1;
                state_next = MODIFY;
            end
            MODIFY: begin
                state_next = WRITE;
            end
            WRITE: begin
                mem_addr    = cur_addr;
                mem_wr_en   = 1'b1;
                mem_wr_data = new_val;
                if (last) begin
                    state_next = FLAG;
                end else begin
                    idx_next   = idx + 1'b1;
                    state_next = SCAN;
                end
            end
            FLAG: begin
                global_writing_flag = 1'b1;
                idx_next            = '0;
                state_next          = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

`ifdef PHER_STATS_EN
    logic [15:0] cnt;
    logic [15:0] cnt_inc;

    sat_add #(
        .WIDTH (16)
    ) u_cnt (
        .a   (cnt),
        .b   (16'd1),
        .sum (cnt_inc)
    );

    always_ff @(posedge game_clk or posedge RESET) begin
        if (RESET) begin
            cnt <= '0;
        end else if (state == SCAN && ant_dropping[idx]) begin
            cnt <= cnt_inc;
        end
    end

    assign sugar_delivered = cnt;
`else
    logic unused_dropping;

    assign unused_dropping = ^ant_dropping;
    assign sugar_delivered = '0;
`endif

endmodule
